// File: rtl/sar_search.sv
// Successive-approximation search controller driving an external combinational
// comparator; finds the target exactly or returns the largest trial <= target.
module sar_search #(
   parameter int size = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   output logic [size-1:0] trial,
   input  logic            cmp_gt,
   input  logic            cmp_lt,
   input  logic            cmp_eq,
   output logic [size-1:0] result,
   output logic            busy,
   output logic            done,
   output logic            found,
   output logic            cmp_err
);

   localparam int IW = (size > 1) ? $clog2(size) : 1;

   typedef enum logic [1:0] {IDLE, EVAL, DONE} state_t;

   state_t          state;
   logic [IW-1:0]   index;
   logic [size-1:0] upd;
   logic [size-1:0] step;
   logic            cmp_ok;

   assign cmp_ok = ({cmp_gt, cmp_lt, cmp_eq} == 3'b100) ||
                   ({cmp_gt, cmp_lt, cmp_eq} == 3'b010) ||
                   ({cmp_gt, cmp_lt, cmp_eq} == 3'b001);

   // upd resolves the current bit; step also sets the next bit to try
   always_comb begin
      upd = trial;
      if (cmp_gt) upd[index] = 1'b0;
      step = upd;
      if (index != '0) step[index - IW'(1)] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         trial   <= '0;
         result  <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         found   <= 1'b0;
         cmp_err <= 1'b0;
         index   <= IW'(size - 1);
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  trial   <= {1'b1, {(size-1){1'b0}}};
                  index   <= IW'(size - 1);
                  found   <= 1'b0;
                  cmp_err <= 1'b0;
                  busy    <= 1'b1;
                  state   <= EVAL;
               end else begin
                  trial <= '0;
               end
            end
            EVAL: begin
               if (!cmp_ok) begin
                  cmp_err <= 1'b1;
                  found   <= 1'b0;
                  result  <= '0;
                  trial   <= '0;
                  busy    <= 1'b0;
                  state   <= DONE;
               end else if (cmp_eq) begin
                  result <= trial;
                  found  <= 1'b1;
                  trial  <= '0;
                  busy   <= 1'b0;
                  state  <= DONE;
               end else if (index == '0) begin
                  result <= upd;
                  found  <= 1'b0;
                  trial  <= '0;
                  busy   <= 1'b0;
                  state  <= DONE;
               end else begin
                  trial <= step;
                  index <= index - IW'(1);
               end
            end
            DONE: begin
               done  <= 1'b1;
               trial <= '0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sar_search.sv
// Bench for sar_search: comparator modelled from a target value, expectations
// derived from bit-prefix arithmetic on the target.
module tb_sar_search;
   localparam int size = 4;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            start = 1'b0;
   logic [size-1:0] trial;
   logic [size-1:0] result;
   logic            cmp_gt, cmp_lt, cmp_eq;
   logic            busy, done, found, cmp_err;

   int target = 0;
   int mode = 0;      // 0 = honest comparator, 1 = gt&lt both high, 2 = all low
   int errors = 0;
   int checks = 0;

   sar_search #(.size(size)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .trial(trial),
      .cmp_gt(cmp_gt), .cmp_lt(cmp_lt), .cmp_eq(cmp_eq),
      .result(result), .busy(busy), .done(done), .found(found), .cmp_err(cmp_err)
   );

   always #5 clk = ~clk;

   assign cmp_gt = (mode == 0) ? (int'(trial) > target)  : (mode == 1);
   assign cmp_lt = (mode == 0) ? (int'(trial) < target)  : (mode == 1);
   assign cmp_eq = (mode == 0) ? (int'(trial) == target) : 1'b0;

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic step_clk();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Runs one search; pulse_mid pulses start during EVAL to show it is ignored.
   task automatic run_search(input int t, input int m, input bit pulse_mid);
      int exp_trials[$];
      int got_trials[$];
      int exp_res, exp_found, exp_err, exp_done, cyc, done_cyc;
      target = t;
      mode = m;
      // Expected trials: keep target bits above j, set bit j, stop on equality.
      if (m == 0) begin
         for (int j = size - 1; j >= 0; j--) begin
            int tr;
            tr = ((t >> (j + 1)) << (j + 1)) | (1 << j);
            exp_trials.push_back(tr);
            if (tr == t) break;
         end
         exp_res = t;
         exp_found = (t != 0);
         exp_err = 0;
      end else begin
         exp_trials.push_back(1 << (size - 1));
         exp_res = 0;
         exp_found = 0;
         exp_err = 1;
      end
      exp_done = exp_trials.size() + 1;

      @(negedge clk);
      start = 1'b1;
      step_clk();
      start = 1'b0;
      cyc = 0;
      done_cyc = -1;
      while (cyc < 20 && done_cyc < 0) begin
         if (busy) got_trials.push_back(int'(trial));
         if (pulse_mid && cyc == 1) start = 1'b1;
         if (pulse_mid && cyc == 2) start = 1'b0;
         if (done) done_cyc = cyc;
         else begin
            step_clk();
            cyc++;
         end
      end
      start = 1'b0;
      chk($sformatf("done_cycle t=%0d m=%0d", t, m), done_cyc, exp_done);
      chk($sformatf("ntrials t=%0d m=%0d", t, m), got_trials.size(), exp_trials.size());
      for (int i = 0; i < exp_trials.size() && i < got_trials.size(); i++)
         chk($sformatf("trial%0d t=%0d", i, t), got_trials[i], exp_trials[i]);
      chk($sformatf("result t=%0d m=%0d", t, m), int'(result), exp_res);
      chk($sformatf("found t=%0d m=%0d", t, m), int'(found), exp_found);
      chk($sformatf("cmp_err t=%0d m=%0d", t, m), int'(cmp_err), exp_err);
      step_clk();
      chk($sformatf("done_pulse t=%0d", t), int'(done), 0);
      chk($sformatf("idle_busy t=%0d", t), int'(busy), 0);
      chk($sformatf("hold_result t=%0d", t), int'(result), exp_res);
      mode = 0;
   endtask

   initial begin
      #2;
      chk("rst_trial", int'(trial), 0);
      chk("rst_result", int'(result), 0);
      chk("rst_flags", int'({busy, done, found, cmp_err}), 0);
      @(negedge clk);
      rst_n = 1'b1;
      step_clk();
      chk("idle_trial", int'(trial), 0);
      chk("idle_busy", int'(busy), 0);

      run_search(5, 0, 1'b0);
      run_search(15, 0, 1'b0);
      run_search(0, 0, 1'b0);
      run_search(8, 0, 1'b0);
      run_search(3, 1, 1'b0);
      run_search(3, 2, 1'b0);
      run_search(6, 0, 1'b1);

      // Asynchronous reset in the second EVAL cycle
      target = 11;
      @(negedge clk);
      start = 1'b1;
      step_clk();
      start = 1'b0;
      step_clk();
      chk("pre_rst_busy", int'(busy), 1);
      #1 rst_n = 1'b0;
      #1;
      chk("mid_rst_trial", int'(trial), 0);
      chk("mid_rst_result", int'(result), 0);
      chk("mid_rst_flags", int'({busy, done, found, cmp_err}), 0);
      @(negedge clk);
      rst_n = 1'b1;
      run_search(11, 0, 1'b0);

      for (int n = 0; n < 10; n++)
         run_search(int'($urandom_range(0, (1 << size) - 1)), 0, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
